create_e_gen: RTL

- Parametrised successor to the fixed 64-bit public-exponent generator in the RSA key-setup path.
- Given L (lambda of the modulus), searches odd candidates upward from a configurable start value.
- Returns the first candidate E with gcd(E, L) = 1 and E < L.
- The gcd is computed iteratively (binary/Stein, one step per cycle), so any width is supported without a wide divider.

---
 rtl/create_e_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/create_e_gen.sv
// Public-exponent search: first odd E >= E_INIT with gcd(E, L) = 1 and E < L (binary gcd).
// Optional candidate limit enabled by defining CREATE_E_TIMEOUT_EN.
module create_e_gen #(
  parameter int unsigned W         = 64,
  parameter logic [W-1:0] E_INIT   = W'(65537),
  parameter int unsigned CW        = 16,
  parameter int unsigned MAX_TRIES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  L,
  input  logic          start_n,
  output logic [W-1:0]  E,
  output logic          ready_n,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] tries
);

  if (E_INIT[0] == 1'b0 || E_INIT < W'(3)) begin : g_bad_einit
    $error("create_e_gen: E_INIT must be odd and >= 3");
  end

  typedef enum logic [2:0] {StIdle, StLoad, StGcd, StNext, StDone} state_e;

  state_e       state;
  logic [W-1:0] lr, cand, a, b;
  logic [W:0]   cand_nxt;
  logic [W-1:0] gcd_val;
  logic         gcd_exit;
  logic         tmo;

  always_comb begin
    cand_nxt = {1'b0, cand} + (W+1)'(2);
    gcd_exit = (a == '0) || (b == '0);
    gcd_val  = (a == '0) ? b : a;
  end

`ifdef CREATE_E_TIMEOUT_EN
  if (MAX_TRIES == 0) begin : g_bad_max
    $error("create_e_gen: MAX_TRIES must be nonzero");
  end
  assign tmo = (tries == CW'(MAX_TRIES));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      E       <= '0;
      ready_n <= 1'b1;
      busy    <= 1'b0;
      err     <= 1'b0;
      tries   <= '0;
      lr      <= '0;
      cand    <= '0;
      a       <= '0;
      b       <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (!start_n) begin
            lr      <= L;
            cand    <= E_INIT;
            tries   <= '0;
            ready_n <= 1'b1;
            busy    <= 1'b1;
            err     <= 1'b0;
            state   <= StLoad;
          end
        end
        StLoad: begin
          if (cand >= lr) begin
            state   <= StDone;
            err     <= 1'b1;
            E       <= '0;
            ready_n <= 1'b0;
            busy    <= 1'b0;
          end else begin
            a     <= lr;
            b     <= cand;
            tries <= tries + CW'(tries != '1);
            state <= StGcd;
          end
        end
        StGcd: begin
          if (gcd_exit) begin
            if (gcd_val == W'(1)) begin
              E       <= cand;
              err     <= 1'b0;
              ready_n <= 1'b0;
              busy    <= 1'b0;
              state   <= StDone;
            end else begin
              state <= StNext;
            end
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a >= b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
        StNext: begin
          // Carry out of W bits means the candidate space is exhausted.
          if (tmo || cand_nxt[W] || (cand_nxt[W-1:0] >= lr)) begin
            state   <= StDone;
            err     <= 1'b1;
            E       <= '0;
            ready_n <= 1'b0;
            busy    <= 1'b0;
          end else begin
            cand  <= cand_nxt[W-1:0];
            state <= StLoad;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
